dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache in the MEM stage.
//  Serves loads and stores from the pipeline and refills lines from a word-wide memory port.
//  Produces cacheStall, which the hazard unit uses to freeze IF/ID and hold the pipeline.
// PARAMETERS
//  SETS   64  number of lines (power of 2, >=2)
//  WORDS  4   32-bit words per line (power of 2, >=2)
//  Derived: OFF=log2(WORDS), IDX=log2(SETS), TAG=30-IDX-OFF
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  memReadM    in   1   load in MEM stage
//  memWriteM   in   1   store in MEM stage (word only; addrM[1:0] ignored)
//  addrM       in   32  byte address of access
//  writeDataM  in   32  store data
//  readDataM   out  32  load data, valid when memReadM && !cacheStall
//  cacheStall  out  1   hold pipeline (combinational)
//  memReq      out  1   request to memory, held until memReady
//  memWrite    out  1   1=write request, 0=read request (qualified by memReq)
//  memAddr     out  32  word-aligned request address
//  memWData    out  32  write data
//  memReady    in   1   memory accepts request this cycle
//  memRValid   in   1   read response valid (exactly one per accepted read)
//  memRData    in   32  read response data
// BEHAVIOUR
//  Storage: valid[SETS], tag[SETS], data[SETS][WORDS]; hit = valid[idx] && tag[idx]==addrM tag.
//  FSM states: IDLE, RREQ, RWAIT, WREQ, WDONE. Reset -> IDLE, all valid=0, wordCnt=0.
//  Reset outputs: cacheStall=0, memReq=0, memWrite=0, memAddr=0, memWData=0, readDataM=0.
//  IDLE:
//   - load hit: readDataM=data[idx][off] same cycle, cacheStall=0, stay IDLE.
//   - load miss: cacheStall=1, latch line base (addrM with offset/byte bits zero) and tag,
//     wordCnt=0 -> RREQ.
//   - store (any hit/miss): cacheStall=1, latch addr/data -> WREQ.
//   - memWriteM && memReadM together: store takes priority (illegal from pipeline).
//  RREQ: cacheStall=1, memReq=1, memWrite=0, memAddr=base+4*wordCnt; on memReady -> RWAIT.
//  RWAIT: cacheStall=1, memReq=0; on memRValid write memRData to data[idx][wordCnt]:
//   - wordCnt!=WORDS-1: wordCnt++ -> RREQ.
//   - last word: set valid[idx]=1, tag[idx]=latched tag -> IDLE (next cycle hits, stall drops).
//   - One outstanding read at a time; miss penalty = WORDS*(req+resp) cycles + 1.
//  WREQ: cacheStall=1, memReq=1, memWrite=1, memAddr/memWData=latched; on memReady:
//   if latched addr hits, update data[idx][off] (no allocate on miss) -> WDONE.
//  WDONE: cacheStall=0 for exactly one cycle so the store retires; -> IDLE unconditionally.
//  memRValid outside RWAIT is ignored. memReady while memReq=0 is ignored.
//  valid[idx] is cleared at refill start (RREQ entry) so a partial line never hits.
//  Reset mid-refill/mid-write: abort to IDLE, drop request, all lines invalid.
//  memReq/memAddr/memWData stable while memReq=1 and !memReady.
// TESTING
//  1 Load 0x100 after reset, memReady=1, resp 1 cycle later, words 0xA0..0xA3 -> 4 reqs
//    addrs 0x100,0x104,0x108,0x10C; stall high until line valid; then readDataM=0xA0, stall=0.
//  2 Follow-up load 0x108 -> hit, readDataM=0xA2 same cycle, no memReq, cacheStall=0.
//  3 Store 0xDEAD to 0x104 (hit) with memReady delayed 3 cycles -> memReq held 3 cycles stable,
//    one WDONE cycle stall=0; later load 0x104 hits returning 0xDEAD.
//  4 Store to 0x2000 (miss) -> memory write issued, line not allocated; load 0x2000 misses.
//  5 Conflict: load 0x100 then 0x100+SETS*WORDS*4 -> second refills same index, first re-misses.
//  6 Assert rst during RWAIT after 2 words -> IDLE, memReq=0, reload of 0x100 misses and refills fully.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache for the MEM stage.
// Loads that hit return data combinationally; misses refill a whole line one word
// at a time over a word-wide memory port. Stores always go to memory and update
// the cached copy only when the line is resident. cacheStall freezes the pipeline.
module dcache_ctrl #(
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        cacheStall,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memReady,
  input  logic        memRValid,
  input  logic [31:0] memRData
);

  localparam int OFF = $clog2(WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 30 - IDX - OFF;
  localparam logic [OFF-1:0] LAST_WORD = OFF'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RWAIT = 3'd2,
    WREQ  = 3'd3,
    WDONE = 3'd4
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  // Line storage: valid bits are reset, tags and data are plain arrays.
  logic [SETS-1:0] valid_r;
  logic [TAG-1:0]  tags_r [SETS];
  logic [31:0]     data_r [SETS][WORDS];

  // Refill and store bookkeeping.
  logic [31:0]    base_addr_r;
  logic [OFF-1:0] wordcnt_r;
  logic [31:0]    wr_addr_r;
  logic [31:0]    wr_data_r;

  // Address fields of the live pipeline access.
  logic [OFF-1:0] a_off_s;
  logic [IDX-1:0] a_idx_s;
  logic [TAG-1:0] a_tag_s;
  logic           a_hit_s;

  // Address fields of the latched refill line and latched store.
  logic [IDX-1:0] r_idx_s;
  logic [TAG-1:0] r_tag_s;
  logic [OFF-1:0] w_off_s;
  logic [IDX-1:0] w_idx_s;
  logic [TAG-1:0] w_tag_s;
  logic           w_hit_s;
  logic [31:0]    fill_addr_s;

  // Per-cycle update strobes produced by the FSM.
  logic start_refill_s;
  logic start_write_s;
  logic fill_word_s;
  logic fill_last_s;
  logic wr_update_s;

  assign a_off_s = addrM[OFF+1:2];
  assign a_idx_s = addrM[IDX+OFF+1:OFF+2];
  assign a_tag_s = addrM[31:IDX+OFF+2];
  assign a_hit_s = valid_r[a_idx_s] && (tags_r[a_idx_s] == a_tag_s);

  assign r_idx_s = base_addr_r[IDX+OFF+1:OFF+2];
  assign r_tag_s = base_addr_r[31:IDX+OFF+2];
  assign w_off_s = wr_addr_r[OFF+1:2];
  assign w_idx_s = wr_addr_r[IDX+OFF+1:OFF+2];
  assign w_tag_s = wr_addr_r[31:IDX+OFF+2];
  assign w_hit_s = valid_r[w_idx_s] && (tags_r[w_idx_s] == w_tag_s);

  // Base has zero offset bits, so OR-ing the word offset in is an add.
  assign fill_addr_s = base_addr_r | {{(30 - OFF){1'b0}}, wordcnt_r, 2'b00};

  // FSM state register; reset aborts any refill or write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, pipeline stall, memory port outputs and update strobes.
  always_comb begin
    state_nx_s     = state_r;
    cacheStall     = 1'b0;
    memReq         = 1'b0;
    memWrite       = 1'b0;
    memAddr        = 32'd0;
    memWData       = 32'd0;
    readDataM      = 32'd0;
    start_refill_s = 1'b0;
    start_write_s  = 1'b0;
    fill_word_s    = 1'b0;
    fill_last_s    = 1'b0;
    wr_update_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (memWriteM) begin
          // Stores win over a simultaneous load.
          cacheStall    = 1'b1;
          start_write_s = 1'b1;
          state_nx_s    = WREQ;
        end else if (memReadM) begin
          if (a_hit_s) begin
            readDataM = data_r[a_idx_s][a_off_s];
          end else begin
            cacheStall     = 1'b1;
            start_refill_s = 1'b1;
            state_nx_s     = RREQ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RREQ: begin
        cacheStall = 1'b1;
        memReq     = 1'b1;
        memAddr    = fill_addr_s;
        if (memReady) begin
          state_nx_s = RWAIT;
        end else begin
          state_nx_s = RREQ;
        end
      end
      RWAIT: begin
        cacheStall = 1'b1;
        if (memRValid) begin
          fill_word_s = 1'b1;
          if (wordcnt_r == LAST_WORD) begin
            fill_last_s = 1'b1;
            state_nx_s  = IDLE;
          end else begin
            state_nx_s = RREQ;
          end
        end else begin
          state_nx_s = RWAIT;
        end
      end
      WREQ: begin
        cacheStall = 1'b1;
        memReq     = 1'b1;
        memWrite   = 1'b1;
        memAddr    = wr_addr_r;
        memWData   = wr_data_r;
        if (memReady) begin
          wr_update_s = w_hit_s;
          state_nx_s  = WDONE;
        end else begin
          state_nx_s = WREQ;
        end
      end
      WDONE: begin
        // One unstalled cycle lets the store retire from MEM.
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Refill/store latches and the word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_r <= 32'd0;
      wordcnt_r   <= '0;
      wr_addr_r   <= 32'd0;
      wr_data_r   <= 32'd0;
    end else begin
      if (start_refill_s) begin
        base_addr_r <= {addrM[31:OFF+2], {(OFF + 2){1'b0}}};
        wordcnt_r   <= '0;
      end else if (fill_word_s && !fill_last_s) begin
        wordcnt_r <= wordcnt_r + 1'b1;
      end else begin
        wordcnt_r <= wordcnt_r;
      end
      if (start_write_s) begin
        wr_addr_r <= addrM & 32'hFFFF_FFFC;
        wr_data_r <= writeDataM;
      end else begin
        wr_addr_r <= wr_addr_r;
      end
    end
  end

  // Valid bits: cleared when a refill starts so a partial line never hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (start_refill_s) begin
      valid_r[a_idx_s] <= 1'b0;
    end else if (fill_last_s) begin
      valid_r[r_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays: refill words, final tag, and store-hit updates.
  always_ff @(posedge clk) begin
    if (!rst && fill_word_s) begin
      data_r[r_idx_s][wordcnt_r] <= memRData;
    end
    if (!rst && fill_last_s) begin
      tags_r[r_idx_s] <= r_tag_s;
    end
    if (!rst && wr_update_s) begin
      data_r[w_idx_s][w_off_s] <= wr_data_r;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised scoreboard bench for dcache_ctrl. A reference memory plus a record of
// which line each set holds predicts load data, hit/miss and memory traffic; a
// memory responder serves the DUT and a monitor pops expectations as events occur.
module tb_dcache_ctrl;

  localparam int SETS  = 64;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadM;
  logic        memWriteM;
  logic [31:0] addrM;
  logic [31:0] writeDataM;
  logic [31:0] readDataM;
  logic        cacheStall;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memReady;
  logic        memRValid;
  logic [31:0] memRData;

  dcache_ctrl #(.SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .memReadM(memReadM), .memWriteM(memWriteM),
    .addrM(addrM), .writeDataM(writeDataM), .readDataM(readDataM),
    .cacheStall(cacheStall), .memReq(memReq), .memWrite(memWrite),
    .memAddr(memAddr), .memWData(memWData), .memReady(memReady),
    .memRValid(memRValid), .memRData(memRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  req_t        exp_req[$];
  logic [31:0] exp_load[$];

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  logic        res_v    [SETS];
  logic [31:0] res_line [SETS];

  logic ready_always = 1'b0;
  int   force_wait   = 0;
  int   rvalid_cnt   = 0;

  function automatic logic [31:0] init_word(input logic [31:0] w);
    return {w[15:0] ^ 16'hBEEF, w[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] w);
    if (phys_mem.exists(w)) return phys_mem[w];
    return init_word(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory responder: drives memReady, returns read data one or more cycles later.
  initial begin : responder
    logic        pend;
    logic [31:0] paddr;
    int          pcnt;
    pend = 1'b0; paddr = 32'd0; pcnt = 0;
    memReady = 1'b0; memRValid = 1'b0; memRData = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      memRValid = 1'b0;
      if (rst) begin
        pend = 1'b0;
        memReady = 1'b0;
      end else begin
        if (pend) begin
          if (pcnt == 0) begin
            memRValid = 1'b1;
            memRData  = phys_rd(paddr >> 2);
            pend = 1'b0;
            rvalid_cnt++;
          end else begin
            pcnt--;
          end
        end else begin
          memRData = $urandom();
        end
        if (memReq && force_wait > 0) begin
          memReady = 1'b0;
          force_wait--;
        end else if (ready_always) begin
          memReady = 1'b1;
        end else begin
          memReady = ($urandom_range(0, 2) != 0);
        end
        #1;
        if (memReq && memReady) begin
          if (memWrite) begin
            phys_mem[memAddr >> 2] = memWData;
          end else begin
            pend  = 1'b1;
            paddr = memAddr;
            pcnt  = ready_always ? 0 : $urandom_range(0, 2);
          end
        end
      end
    end
  end

  // Monitor: pops expected memory requests and load results as the DUT presents them.
  initial begin : monitor
    logic        hold;
    logic [31:0] h_addr, h_data;
    logic        h_wr;
    req_t        e;
    logic [31:0] ld;
    hold = 1'b0; h_addr = 32'd0; h_data = 32'd0; h_wr = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold && memReq) begin
          chk("req_hold_addr", memAddr, h_addr);
          chk("req_hold_wdata", memWData, h_data);
          chk("req_hold_write", 32'(memWrite), 32'(h_wr));
        end
        if (memReq && memReady) begin
          if (exp_req.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            e = exp_req.pop_front();
            chk("req_write", 32'(memWrite), 32'(e.wr));
            chk("req_addr", memAddr, e.addr);
            if (e.wr) chk("req_wdata", memWData, e.data);
          end
        end
        hold   = memReq && !memReady;
        h_addr = memAddr;
        h_data = memWData;
        h_wr   = memWrite;
        if (memReadM && !memWriteM && !cacheStall) begin
          if (exp_load.size() == 0) begin
            fail_now("unexpected_load_done");
          end else begin
            ld = exp_load.pop_front();
            chk("load_data", readDataM, ld);
          end
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, output int stalls);
    logic [31:0] line;
    int          idx;
    logic        exp_hit;
    req_t        r;
    line    = addr >> 4;
    idx     = int'(line % SETS);
    exp_hit = res_v[idx] && (res_line[idx] == line);
    if (!exp_hit) begin
      for (int i = 0; i < WORDS; i++) begin
        r.wr = 1'b0; r.addr = (line << 4) + 32'(4 * i); r.data = 32'd0;
        exp_req.push_back(r);
      end
      res_v[idx]    = 1'b1;
      res_line[idx] = line;
    end
    exp_load.push_back(ref_rd(addr >> 2));
    @(negedge clk);
    memReadM = 1'b1; memWriteM = 1'b0; addrM = addr; writeDataM = $urandom();
    #4;
    chk("load_first_stall", 32'(cacheStall), 32'(!exp_hit));
    stalls = 0;
    while (cacheStall === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk);
      #4;
    end
    if (stalls >= 400) fail_now("load_timeout");
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic both, output int stalls);
    req_t r;
    ref_mem[addr >> 2] = data;
    r.wr = 1'b1; r.addr = addr & 32'hFFFF_FFFC; r.data = data;
    exp_req.push_back(r);
    @(negedge clk);
    memWriteM = 1'b1; memReadM = both; addrM = addr; writeDataM = data;
    #4;
    chk("store_first_stall", 32'(cacheStall), 32'd1);
    stalls = 0;
    while (cacheStall === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk);
      #4;
    end
    if (stalls >= 400) fail_now("store_timeout");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    memReadM = 1'b0; memWriteM = 1'b0; addrM = $urandom(); writeDataM = $urandom();
  endtask

  initial begin : main
    int          st;
    int          n;
    int          base;
    logic [31:0] pool [6];
    logic [31:0] a;
    pool[0] = 32'h010; pool[1] = 32'h050; pool[2] = 32'h200;
    pool[3] = 32'h090; pool[4] = 32'h011; pool[5] = 32'h3FF;
    for (int i = 0; i < SETS; i++) begin res_v[i] = 1'b0; res_line[i] = 32'd0; end
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[32'h40 + 32'(i)]  = 32'hA0 + 32'(i);
      phys_mem[32'h40 + 32'(i)] = 32'hA0 + 32'(i);
    end
    rst = 1'b1; memReadM = 1'b0; memWriteM = 1'b0; addrM = 32'd0; writeDataM = 32'd0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_readData", readDataM, 32'd0);
    chk("rst_stall", 32'(cacheStall), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWData", memWData, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss with an always-ready memory answering one cycle later.
    ready_always = 1'b1;
    do_load(32'h100, st);
    chk("miss_penalty", 32'(st), 32'(2 * WORDS + 1));
    // Same line, other word: hit with no stall.
    do_load(32'h108, st);
    chk("hit_no_stall", 32'(st), 32'd0);
    // Store hit with memReady held off for three cycles.
    force_wait = 3;
    do_store(32'h104, 32'hDEAD, 1'b0, st);
    chk("store_stall_cycles", 32'(st), 32'd5);
    idle_cycle();
    do_load(32'h104, st);
    chk("store_hit_reload", 32'(st), 32'd0);
    // Store miss is not allocated; the following load misses.
    do_store(32'h2000, 32'h1234_5678, 1'b0, st);
    do_load(32'h2000, st);
    // Conflicting line in the same set evicts the first one.
    do_load(32'h100 + 32'(SETS * WORDS * 4), st);
    do_load(32'h100, st);
    do_load(32'h100 + 32'(SETS * WORDS * 4), st);
    // Load and store together: store wins.
    do_store(32'h50C, 32'hCAFE_F00D, 1'b1, st);
    do_load(32'h50C, st);

    // Reset in the middle of a refill.
    ready_always = 1'b0;
    idle_cycle();
    base = rvalid_cnt;
    begin
      req_t r;
      for (int i = 0; i < WORDS; i++) begin
        r.wr = 1'b0; r.addr = 32'h100 + 32'(4 * i); r.data = 32'd0;
        exp_req.push_back(r);
      end
    end
    @(negedge clk);
    memReadM = 1'b1; addrM = 32'h100;
    n = 0;
    while (rvalid_cnt < base + 2 && n < 400) begin
      n++;
      @(negedge clk);
      #4;
    end
    if (n >= 400) fail_now("midfill_timeout");
    @(negedge clk);
    rst = 1'b1; memReadM = 1'b0;
    exp_req.delete();
    exp_load.delete();
    for (int i = 0; i < SETS; i++) res_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("midfill_rst_memReq", 32'(memReq), 32'd0);
    chk("midfill_rst_stall", 32'(cacheStall), 32'd0);
    do_load(32'h100, st);
    do_load(32'h10C, st);

    // Randomised mix over a handful of conflicting lines.
    for (int k = 0; k < 250; k++) begin
      a = (pool[$urandom_range(0, 5)] << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6) begin
        do_load(a, st);
      end else begin
        do_store(a, $urandom(), ($urandom_range(0, 7) == 0), st);
      end
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    repeat (4) idle_cycle();
    #4;
    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("load_queue_empty", 32'(exp_load.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a wedged DUT.
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
